layer_stream_io: RTL and testbench

LAYER_STREAM_IO -- requirements
Module: layer_stream_io

---
 rtl/dnn_pkg.sv | 20 ++
 rtl/layer_out_serializer.sv | 64 ++++++
 rtl/layer_stream_io.sv | 134 +++++++++++++
 tb/tb_layer_stream_io.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared word type, FSM state encoding and counter sizing helper for the layer
// streaming blocks.
package dnn_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    // Counter width for a count range, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/layer_out_serializer.sv
// Snapshots the parallel layer results and streams them out one word per
// handshake, flagging the final word with out_last_o.
module layer_out_serializer
    import dnn_pkg::*;
#(
    parameter int OUTPUT_NEURON_COUNT = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  capture_i,
    input  logic                                  start_i,
    input  logic [WORD_W*OUTPUT_NEURON_COUNT-1:0] acc_out_i,
    input  logic                                  out_ready_i,
    output logic                                  out_valid_o,
    output logic [WORD_W-1:0]                     out_data_o,
    output logic                                  out_last_o,
    output logic                                  done_o
);

    localparam int CW = cnt_width(OUTPUT_NEURON_COUNT);

    word_t          res_buf_q [OUTPUT_NEURON_COUNT];
    logic  [CW-1:0] out_cnt_q;
    logic           active_q;
    logic           at_last;
    logic           xfer;

    assign at_last = (out_cnt_q == CW'(OUTPUT_NEURON_COUNT - 1));
    assign xfer    = active_q && out_ready_i;
    assign done_o  = xfer && at_last;

    assign out_valid_o = active_q;
    assign out_data_o  = res_buf_q[out_cnt_q];
    assign out_last_o  = active_q && at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            active_q  <= 1'b0;
            out_cnt_q <= '0;
            // NOTE: the result buffer is cleared on reset because out_data exposes it directly.
            for (int o = 0; o < OUTPUT_NEURON_COUNT; o++) begin
                res_buf_q[o] <= '0;
            end
        end else begin
            if (capture_i) begin
                for (int o = 0; o < OUTPUT_NEURON_COUNT; o++) begin
                    res_buf_q[o] <= acc_out_i[o*WORD_W +: WORD_W];
                end
            end

            if (start_i) begin
                active_q <= 1'b1;
            end else if (done_o) begin
                active_q <= 1'b0;
            end

            if (xfer) begin
                out_cnt_q <= at_last ? '0 : out_cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/layer_stream_io.sv
// Stream front-end for one dense layer: collects weights and an input vector,
// presents them in parallel to the datapath, then serialises the results.
module layer_stream_io
    import dnn_pkg::*;
#(
    parameter int INPUT_NEURON_COUNT  = 15,
    parameter int OUTPUT_NEURON_COUNT = 15
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     w_valid,
    output logic                                                     w_ready,
    input  logic [WORD_W-1:0]                                        w_data,
    input  logic                                                     in_valid,
    output logic                                                     in_ready,
    input  logic [WORD_W-1:0]                                        in_data,
    output logic [WORD_W*INPUT_NEURON_COUNT-1:0]                     acc_inputs,
    output logic [WORD_W*OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT-1:0] acc_weights,
    input  logic [WORD_W*OUTPUT_NEURON_COUNT-1:0]                    acc_out,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic [WORD_W-1:0]                                        out_data,
    output logic                                                     out_last
);

    localparam int W_COUNT = OUTPUT_NEURON_COUNT * INPUT_NEURON_COUNT;
    localparam int IN_CW   = cnt_width(INPUT_NEURON_COUNT);
    localparam int W_CW    = cnt_width(W_COUNT);

    state_t            state_q, state_d;
    logic  [IN_CW-1:0] in_cnt_q, in_cnt_d;
    logic  [W_CW-1:0]  w_cnt_q, w_cnt_d;
    word_t             in_buf_q [INPUT_NEURON_COUNT];
    word_t             w_buf_q  [W_COUNT];

    logic in_acc;
    logic w_acc;
    logic capture;
    logic start;
    logic ser_done;

    // Weights are only accepted between frames so a frame never sees a mix.
    assign in_ready = (state_q == LOAD);
    assign w_ready  = (state_q == LOAD) && (in_cnt_q == '0);
    assign in_acc   = in_valid && in_ready;
    assign w_acc    = w_valid && w_ready;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        w_cnt_d  = w_cnt_q;
        capture  = 1'b0;
        start    = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    if (in_cnt_q == IN_CW'(INPUT_NEURON_COUNT - 1)) begin
                        in_cnt_d = '0;
                        state_d  = CAPTURE;
                    end else begin
                        in_cnt_d = in_cnt_q + IN_CW'(1);
                    end
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                start   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (ser_done) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        if (w_acc) begin
            w_cnt_d = (w_cnt_q == W_CW'(W_COUNT - 1)) ? '0 : w_cnt_q + W_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOAD;
            in_cnt_q <= '0;
            w_cnt_q  <= '0;
            for (int i = 0; i < INPUT_NEURON_COUNT; i++) begin
                in_buf_q[i] <= '0;
            end
            for (int k = 0; k < W_COUNT; k++) begin
                w_buf_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            w_cnt_q  <= w_cnt_d;
            if (in_acc) begin
                in_buf_q[in_cnt_q] <= in_data;
            end
            if (w_acc) begin
                w_buf_q[w_cnt_q] <= w_data;
            end
        end
    end

    always_comb begin
        acc_inputs  = '0;
        acc_weights = '0;
        for (int i = 0; i < INPUT_NEURON_COUNT; i++) begin
            acc_inputs[i*WORD_W +: WORD_W] = in_buf_q[i];
        end
        for (int k = 0; k < W_COUNT; k++) begin
            acc_weights[k*WORD_W +: WORD_W] = w_buf_q[k];
        end
    end

    layer_out_serializer #(
        .OUTPUT_NEURON_COUNT(OUTPUT_NEURON_COUNT)
    ) u_serializer (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (capture),
        .start_i     (start),
        .acc_out_i   (acc_out),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_layer_stream_io.sv
// Directed bench for layer_stream_io with IN=2, OUT=2; a queue scoreboard
// holds expected result words and a negedge monitor retires them.
module tb_layer_stream_io;

    localparam int IN  = 2;
    localparam int OUT = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_valid;
    logic              w_ready;
    logic [15:0]       w_data;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_data;
    logic [16*IN-1:0]  acc_inputs;
    logic [16*OUT*IN-1:0] acc_weights;
    logic [16*OUT-1:0] acc_out;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              out_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Datapath stand-in: word 0 is the sum of the two activations, word 1 is 7.
    assign acc_out = {16'd7, 16'(acc_inputs[15:0] + acc_inputs[31:16])};

    layer_stream_io #(
        .INPUT_NEURON_COUNT (IN),
        .OUTPUT_NEURON_COUNT(OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .acc_inputs (acc_inputs),
        .acc_weights(acc_weights),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        sb.push_back(e);
    endtask

    // Drives one two-word frame and records the two expected result words.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b);
        push_exp(16'(a + b), 1'b0);
        push_exp(16'd7, 1'b1);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Retire a scoreboard entry whenever a result word transfers at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_word", 64'(out_data), 64'hDEAD_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_last", 64'(out_last), 64'(e.last));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        w_valid   = 1'b0;
        w_data    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_w_ready", 64'(w_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_acc_inputs", 64'(acc_inputs), 64'd0);
        rst = 1'b0;

        // Weight load 1,2,3,4
        w_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            w_data = 16'(k);
            tick();
        end
        w_valid = 1'b0;
        check("acc_weights_load", 64'(acc_weights), 64'h0004_0003_0002_0001);

        // Frame 5,6 with out_ready high: expect 11 then 7
        out_ready = 1'b1;
        send_frame(16'd5, 16'd6);
        check("capture_in_ready", 64'(in_ready), 64'd0);
        check("capture_w_ready", 64'(w_ready), 64'd0);
        check("capture_out_valid", 64'(out_valid), 64'd0);
        check("acc_inputs_5_6", 64'(acc_inputs), 64'h0006_0005);
        tick();
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("send_in_ready", 64'(in_ready), 64'd0);
        wait_drain("drain_frame1");
        check("back_in_load", 64'(in_ready), 64'd1);

        // Backpressure: hold out_ready low for 5 cycles in SEND
        out_ready = 1'b0;
        send_frame(16'd1, 16'd2);
        tick();
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_data", 64'(out_data), 64'd3);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'd3);
            check("bp_hold_last", 64'(out_last), 64'd0);
        end
        out_ready = 1'b1;
        wait_drain("drain_backpressure");

        // Weight and first input word in the same cycle; weight refused mid-frame
        push_exp(16'd8, 1'b0);
        push_exp(16'd7, 1'b1);
        w_valid  = 1'b1;
        w_data   = 16'd9;
        in_valid = 1'b1;
        in_data  = 16'd3;
        check("simul_w_ready_start", 64'(w_ready), 64'd1);
        tick();
        check("simul_w_ready_mid", 64'(w_ready), 64'd0);
        in_data = 16'd5;
        tick();
        w_valid  = 1'b0;
        in_valid = 1'b0;
        check("simul_acc_weights", 64'(acc_weights), 64'h0004_0003_0002_0009);
        check("simul_acc_inputs", 64'(acc_inputs), 64'h0005_0003);
        wait_drain("drain_simul");

        // Reset after one input word discards it
        in_valid = 1'b1;
        in_data  = 16'h0055;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_acc_inputs", 64'(acc_inputs), 64'd0);
        check("mid_rst_acc_weights", 64'(acc_weights), 64'd0);
        check("mid_rst_w_ready", 64'(w_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        send_frame(16'd9, 16'd10);
        check("mid_rst_capture", 64'(acc_inputs), 64'h000A_0009);
        wait_drain("drain_mid_rst");

        // Reset during SEND drops the pending words
        out_ready = 1'b0;
        send_frame(16'd1, 16'd1);
        tick();
        check("send_rst_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("send_rst_out_valid", 64'(out_valid), 64'd0);
        check("send_rst_out_last", 64'(out_last), 64'd0);
        check("send_rst_out_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check("send_rst_no_emit", 64'(out_valid), 64'd0);

        // Back-to-back frames with everything held ready/valid
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int f = 0; f < 3; f++) begin
            int n;
            logic [15:0] a;
            logic [15:0] b;
            a = 16'(2 * f + 1);
            b = 16'(2 * f + 2);
            push_exp(16'(a + b), 1'b0);
            push_exp(16'd7, 1'b1);
            in_data = a;
            tick();
            in_data = b;
            tick();
            in_data = 16'(2 * f + 3);
            check("b2b_capture_valid", 64'(out_valid), 64'd0);
            n = 0;
            do begin
                tick();
                n++;
                if (n == 1) check("b2b_latency", 64'(out_valid), 64'd1);
            end while (!in_ready && n < 20);
            check("b2b_gap_cycles", 64'(n), 64'd3);
        end
        in_valid = 1'b0;
        wait_drain("drain_b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
